// File: rtl/pipes_pkg.sv
// Shared pipeline types: fetch payload, fetch FSM states and pre-decode opcodes.
package pipes;

  localparam logic [5:0] F6_J   = 6'b000010;
  localparam logic [5:0] F6_BEQ = 6'b000100;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        delay_slot;
    logic        jump;
  } fetch_data_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DROP
  } fetch_state_t;

  function automatic logic is_jump(input logic [31:0] instr);
    return (instr[31:26] == F6_J) || (instr[31:26] == F6_BEQ);
  endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer holding a fetched word while the output register is stalled.
module fetch_skid
  import pipes::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        push_i,
  input  fetch_data_t push_data_i,
  input  logic        pop_i,
  input  logic        flush_i,
  output logic        valid_o,
  output fetch_data_t data_o
);

  logic        valid_q, valid_d;
  fetch_data_t data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
      data_d  = '0;
    end else begin
      if (pop_i) valid_d = 1'b0;
      if (push_i) begin
        valid_d = 1'b1;
        data_d  = push_data_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, single-outstanding bus FSM, pre-decode and output register
// feeding decode through a valid/ready handshake.
module fetch_stage
  import pipes::*;
#(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [31:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_valid,
  output fetch_data_t fetch_data,
  input  logic        decode_ready
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  addr_q, addr_d;
  fetch_data_t  out_q, out_d;
  logic         out_valid_q, out_valid_d;
  logic         ds_q, ds_d;

  logic         issue, resp_live, fire;
  logic         skid_valid, skid_push, skid_pop;
  fetch_data_t  skid_data, new_word;

  fetch_skid u_skid (
    .clk         (clk),
    .reset       (reset),
    .push_i      (skid_push),
    .push_data_i (new_word),
    .pop_i       (skid_pop),
    .flush_i     (redirect_valid),
    .valid_o     (skid_valid),
    .data_o      (skid_data)
  );

  always_comb begin
    issue      = reset && (state_q == S_IDLE) && !skid_valid && !redirect_valid;
    ireq_valid = issue || (reset && (state_q != S_IDLE));
    // In S_DROP the bus still sees the abandoned address, not the redirect target.
    ireq_addr  = (state_q == S_IDLE) ? pc_q : addr_q;
    resp_live  = ireq_valid && iresp_data_ok && (state_q != S_DROP) && !redirect_valid;
    fire       = out_valid_q && decode_ready;

    new_word             = '0;
    new_word.pc          = ireq_addr;
    new_word.instruction = iresp_data;
    new_word.delay_slot  = ds_q;
    new_word.jump        = is_jump(iresp_data);

    state_d     = state_q;
    pc_d        = pc_q;
    addr_d      = issue ? pc_q : addr_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    ds_d        = ds_q;
    skid_push   = 1'b0;
    skid_pop    = 1'b0;

    unique case (state_q)
      S_IDLE:  if (issue && !iresp_data_ok) state_d = S_WAIT;
      S_WAIT: begin
        if (iresp_data_ok)       state_d = S_IDLE;
        else if (redirect_valid) state_d = S_DROP;
      end
      S_DROP:  if (iresp_data_ok) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (redirect_valid) begin
      pc_d        = redirect_pc & 32'hFFFF_FFFC;
      out_d       = '0;
      out_valid_d = 1'b0;
      ds_d        = 1'b0;
    end else begin
      if (resp_live) begin
        pc_d = pc_q + 32'd4;
        ds_d = new_word.jump;
      end
      if (!out_valid_q || fire) begin
        if (skid_valid) begin
          out_d       = skid_data;
          out_valid_d = 1'b1;
          skid_pop    = 1'b1;
          skid_push   = resp_live;
        end else if (resp_live) begin
          out_d       = new_word;
          out_valid_d = 1'b1;
        end else begin
          out_valid_d = 1'b0;
        end
      end else begin
        skid_push = resp_live;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      addr_q      <= RESET_PC;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      ds_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      addr_q      <= addr_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      ds_q        <= ds_d;
    end
  end

  assign fetch_valid = out_valid_q;
  assign fetch_data  = out_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: cycle table for streaming/backpressure, plus
// hand sequences for redirects and PC wrap.
module tb_fetch_stage;
  import pipes::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        ireq_valid;
  logic [31:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_valid;
  fetch_data_t fetch_data;
  logic        decode_ready;

  int          lat;
  int          cnt;
  logic [31:0] j_addr;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'hBFC0_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .ireq_valid     (ireq_valid),
    .ireq_addr      (ireq_addr),
    .iresp_data_ok  (iresp_data_ok),
    .iresp_data     (iresp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_valid    (fetch_valid),
    .fetch_data     (fetch_data),
    .decode_ready   (decode_ready)
  );

  // Memory model: answers after `lat` waiting cycles; word is the address except at j_addr.
  assign iresp_data_ok = ireq_valid && (cnt >= lat);
  assign iresp_data    = (ireq_addr == j_addr) ? 32'h0800_0010 : ireq_addr;

  always @(posedge clk) begin
    if (ireq_valid && !iresp_data_ok) cnt <= cnt + 1;
    else cnt <= 0;
  end

  typedef struct {
    logic        ready;
    logic        e_ireq;
    logic [31:0] e_addr;
    logic        e_fv;
    logic [31:0] e_pc;
    logic        e_jump;
    logic        e_ds;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset(input int l);
    @(negedge clk);
    reset          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    decode_ready   = 1'b1;
    lat            = l;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ireq_valid", 66'(ireq_valid), 66'd0);
    chk("rst_fetch_valid", 66'(fetch_valid), 66'd0);
    chk("rst_fetch_data", fetch_data, 66'd0);
  endtask

  task automatic apply(input logic rdy, input logic rv, input logic [31:0] rpc);
    @(negedge clk);
    reset          = 1'b1;
    decode_ready   = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    cnt    = 0;
    j_addr = 32'hBFC0_0000;
    vecs[0] = '{1'b1, 1'b1, 32'hBFC0_0000, 1'b0, 32'h0,          1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 32'hBFC0_0004, 1'b1, 32'hBFC0_0000, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 32'hBFC0_0008, 1'b1, 32'hBFC0_0004, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 1'b0, 32'h0,          1'b1, 32'hBFC0_0004, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 32'h0,          1'b1, 32'hBFC0_0004, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 32'h0,          1'b1, 32'hBFC0_0004, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 32'h0,          1'b1, 32'hBFC0_0004, 1'b0, 1'b1};
    vecs[7] = '{1'b1, 1'b1, 32'hBFC0_000C, 1'b1, 32'hBFC0_0008, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 1'b1, 32'hBFC0_0010, 1'b1, 32'hBFC0_000C, 1'b0, 1'b0};
    vecs[9] = '{1'b1, 1'b1, 32'hBFC0_0014, 1'b1, 32'hBFC0_0010, 1'b0, 1'b0};

    // Streaming, jump/delay-slot marking and backpressure.
    do_reset(0);
    for (int i = 0; i < 10; i++) begin
      apply(vecs[i].ready, 1'b0, 32'h0);
      chk($sformatf("tbl%0d_ireq_valid", i), 66'(ireq_valid), 66'(vecs[i].e_ireq));
      if (vecs[i].e_ireq)
        chk($sformatf("tbl%0d_ireq_addr", i), 66'(ireq_addr), 66'(vecs[i].e_addr));
      chk($sformatf("tbl%0d_fetch_valid", i), 66'(fetch_valid), 66'(vecs[i].e_fv));
      if (vecs[i].e_fv) begin
        chk($sformatf("tbl%0d_pc", i), 66'(fetch_data.pc), 66'(vecs[i].e_pc));
        chk($sformatf("tbl%0d_jump", i), 66'(fetch_data.jump), 66'(vecs[i].e_jump));
        chk($sformatf("tbl%0d_delay_slot", i), 66'(fetch_data.delay_slot), 66'(vecs[i].e_ds));
      end
    end

    // Redirect while waiting on a 3-cycle memory: in-flight word dropped.
    j_addr = 32'h1;
    do_reset(3);
    apply(1'b1, 1'b0, 32'h0);
    chk("wr_c1_ireq_addr", 66'(ireq_addr), 66'h0BFC0_0000);
    apply(1'b1, 1'b1, 32'h8000_0003);
    chk("wr_c2_ireq_valid", 66'(ireq_valid), 66'd1);
    apply(1'b1, 1'b0, 32'h0);
    chk("wr_drop_ireq_valid", 66'(ireq_valid), 66'd1);
    chk("wr_drop_ireq_addr", 66'(ireq_addr), 66'h0BFC0_0000);
    apply(1'b1, 1'b0, 32'h0);
    chk("wr_c4_fetch_valid", 66'(fetch_valid), 66'd0);
    apply(1'b1, 1'b0, 32'h0);
    chk("wr_target_ireq_addr", 66'(ireq_addr), 66'h08000_0000);
    chk("wr_c5_fetch_valid", 66'(fetch_valid), 66'd0);
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 1'b0, 32'h0);
      chk($sformatf("wr_idle%0d_fetch_valid", i), 66'(fetch_valid), 66'd0);
    end
    apply(1'b1, 1'b0, 32'h0);
    chk("wr_fetch_valid", 66'(fetch_valid), 66'd1);
    chk("wr_pc", 66'(fetch_data.pc), 66'h08000_0000);
    chk("wr_delay_slot", 66'(fetch_data.delay_slot), 66'd0);

    // Redirect coinciding with data_ok while output is full.
    do_reset(1);
    apply(1'b1, 1'b0, 32'h0);
    apply(1'b1, 1'b0, 32'h0);
    chk("sc_c2_fetch_valid", 66'(fetch_valid), 66'd0);
    apply(1'b0, 1'b0, 32'h0);
    chk("sc_c3_pc", 66'(fetch_data.pc), 66'h0BFC0_0000);
    chk("sc_c3_ireq_addr", 66'(ireq_addr), 66'h0BFC0_0004);
    apply(1'b0, 1'b1, 32'h8000_0100);
    chk("sc_c4_data_ok", 66'(iresp_data_ok), 66'd1);
    apply(1'b1, 1'b0, 32'h0);
    chk("sc_flush_fetch_valid", 66'(fetch_valid), 66'd0);
    chk("sc_flush_fetch_data", fetch_data, 66'd0);
    chk("sc_target_ireq_valid", 66'(ireq_valid), 66'd1);
    chk("sc_target_ireq_addr", 66'(ireq_addr), 66'h08000_0100);
    apply(1'b1, 1'b0, 32'h0);
    apply(1'b1, 1'b0, 32'h0);
    chk("sc_fetch_valid", 66'(fetch_valid), 66'd1);
    chk("sc_pc", 66'(fetch_data.pc), 66'h08000_0100);

    // PC wrap after redirect to the last word.
    do_reset(0);
    apply(1'b1, 1'b0, 32'h0);
    apply(1'b1, 1'b1, 32'hFFFF_FFFC);
    chk("wrap_redir_ireq_valid", 66'(ireq_valid), 66'd0);
    chk("wrap_redir_pc", 66'(fetch_data.pc), 66'h0BFC0_0000);
    apply(1'b1, 1'b0, 32'h0);
    chk("wrap_c3_fetch_valid", 66'(fetch_valid), 66'd0);
    chk("wrap_c3_ireq_addr", 66'(ireq_addr), 66'h0FFFF_FFFC);
    apply(1'b1, 1'b0, 32'h0);
    chk("wrap_c4_pc", 66'(fetch_data.pc), 66'h0FFFF_FFFC);
    chk("wrap_c4_ireq_addr", 66'(ireq_addr), 66'd0);
    apply(1'b1, 1'b0, 32'h0);
    chk("wrap_c5_fetch_valid", 66'(fetch_valid), 66'd1);
    chk("wrap_c5_pc", 66'(fetch_data.pc), 66'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the five-stage pipeline. Owns the PC and drives the instruction bus with one outstanding request at a time. Captures returned words into a `fetch_data_t` output register backed by a one-entry skid buffer. Feeds the decode stage through a valid/ready handshake and honours redirects from execute.

## Interface
- `RESET_PC`, default `32'hBFC0_0000`: first fetch address after reset.
- `clk  in  1`: pipeline clock; all state updates on the rising edge.
- `reset  in  1`: synchronous, active-low; sampled on the rising edge of `clk`.
- `ireq_valid  out  1`: instruction request outstanding.
- `ireq_addr  out  32`: word address of the request; stable while `ireq_valid` is high.
- `iresp_data_ok  in  1`: response valid. May assert in the same cycle as `ireq_valid` (zero-wait memory).
- `iresp_data  in  32`: instruction word, valid when `iresp_data_ok` is high.
- `redirect_valid  in  1`: branch/jump resolved taken in execute; single-cycle pulse.
- `redirect_pc  in  32`: target address; bits [1:0] are ignored and forced to 0.
- `fetch_valid  out  1`: `fetch_data` holds a live instruction.
- `fetch_data  out  fetch_data_t`: `pc`, `instruction`, `delay_slot`, `jump`.
- `decode_ready  in  1`: decode accepts `fetch_data` this cycle.

## Operation
- **State machine:** `fetch_state_t` with states `S_IDLE`, `S_WAIT`, `S_DROP`.
- **S_IDLE:** a request for `pc` is issued (enter `S_WAIT`, `ireq_valid=1`) when the skid buffer is empty and no redirect is present this cycle.
- **S_WAIT:** `ireq_valid=1`, `ireq_addr=pc`. On `iresp_data_ok`:
  - write the word to the output register if it is empty or being accepted this cycle; otherwise write it to the skid buffer;
  - set `pc <= pc+4`;
  - go to `S_IDLE`.
- **S_DROP:** an outstanding request whose data must be discarded. `ireq_valid` stays 1 with the old address. On `iresp_data_ok`, the data is dropped and the state returns to `S_IDLE`.
- **Redirect** (`redirect_valid=1`, highest priority):
  - `pc <= {redirect_pc[31:2],2'b00}`.
  - Output register and skid buffer are cleared.
  - From `S_WAIT` without `data_ok` this cycle, go to `S_DROP`. From `S_WAIT` with `data_ok` this cycle, the data is dropped and the state goes to `S_IDLE`.
  - In `S_DROP`, the target is updated and the state stays `S_DROP`.
- **Decode handshake:** the output register advances on `fetch_valid && decode_ready`. It refills from the skid buffer if that is full, otherwise from a same-cycle response.
- **Pre-decode:** `jump = (instruction[31:26]==F6_J) || (instruction[31:26]==F6_BEQ)`.
- **Delay slot:** `delay_slot` = `jump` of the previously captured instruction (tracked in a one-bit register). That register is cleared by reset and by redirect.
- **Delay-slot ownership:** execute must not assert a redirect until the delay slot has left fetch. A redirect always flushes everything held in fetch.
- **PC arithmetic:** modulo 2^32; `32'hFFFF_FFFC + 4` wraps to 0.

## Timing
- **During reset:**
  - `ireq_valid=0`, `fetch_valid=0`, `fetch_data='0`;
  - `pc=RESET_PC`, state `S_IDLE`, skid buffer empty, delay-slot flag 0.
- **After reset:** the first cycle with `reset=1` issues the request for `RESET_PC`.
- **Latency:** a response in cycle N gives `fetch_valid=1` in N+1.
- **Throughput:** with zero-wait memory and `decode_ready` held high, one instruction per cycle.
- **Backpressure:** with `decode_ready=0` and output full, at most one further response is absorbed by the skid buffer. No new request is issued until the skid buffer drains.
- **Reset mid-request:** the state is abandoned with no drop tracking. The bus is required to be reset in the same cycle.
- **Output stability:** `fetch_data` is stable while `fetch_valid && !decode_ready`.

## Structure
- **In package `pipes`:** `fetch_state_t` enum, alongside the existing `fetch_data_t` and `F6_J`/`F6_BEQ`.
- **Sub-module `fetch_skid`:** one-entry buffer with valid bit, `fetch_data_t` payload, and push/pop/flush ports.
- **Rest of `fetch_stage`:** FSM, PC register, pre-decode and output register.

## Test plan
- **Reset release, zero-wait memory, `decode_ready=1`:** `fetch_data.pc` = `BFC00000`, `BFC00004`, `BFC00008` on consecutive cycles; `fetch_valid` high from the second post-reset cycle.
- **J word `08000010` fetched at `BFC00000`:** its `jump=1`; the next instruction has `delay_slot=1`; the following one has `delay_slot=0`.
- **Backpressure:** `decode_ready=0` for 4 cycles. Output holds `BFC00004`, skid holds `BFC00008`, `ireq_valid=0`. After release, `BFC00008` and `BFC0000C` follow in order with no loss or duplication.
- **Redirect to `80000003` while in `S_WAIT` with 3-cycle memory latency:** the in-flight word is dropped; the next delivered `pc` is `80000000`; no `fetch_valid` for the dropped word.
- **Redirect in the same cycle as `iresp_data_ok`:** the returned word is discarded and the output register is flushed. The next request address is the target.
- **PC wrap:** redirect to `FFFFFFFC`, then sequential fetch. Delivered pcs are `FFFFFFFC`, then `00000000`.
